// File: rtl/adder15_if.sv
// Operand/result bus for the registered carry-lookahead adder.
// The master drives operands and samples results; the adder sits on the slave side.
interface adder15_if #(
  parameter int unsigned WIDTH = 15
);
  logic             in_valid;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             C;
  logic [WIDTH-1:0] S;
  logic             C_out;
  logic             out_valid;

  modport master (
    output in_valid, A, B, C,
    input  S, C_out, out_valid
  );

  modport slave (
    input  in_valid, A, B, C,
    output S, C_out, out_valid
  );
endinterface

// File: rtl/adder15.sv
// Registered WIDTH-bit adder: {C_out,S} = A + B + C through a two-level
// carry-lookahead network, captured on clk when in_valid is high.
module adder15 #(
  parameter int unsigned WIDTH = 15,
  parameter int unsigned GROUP = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  adder15_if.slave   bus
);

  localparam int unsigned NG = (WIDTH + GROUP - 1) / GROUP;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [NG:0]      cg;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;

  // Bit generate/propagate and group generate/propagate; the last group may be partial.
  always_comb begin
    logic ggk;
    logic gpk;
    g  = bus.A & bus.B;
    p  = bus.A ^ bus.B;
    gg = '0;
    gp = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      ggk = 1'b0;
      gpk = 1'b1;
      for (int unsigned j = 0; j < GROUP; j++) begin
        if (k * GROUP + j < WIDTH) begin
          ggk = g[k*GROUP+j] | (p[k*GROUP+j] & ggk);
          gpk = gpk & p[k*GROUP+j];
        end
      end
      gg[k] = ggk;
      gp[k] = gpk;
    end
  end

  // Second-level lookahead: each group carry is a flat sum of products of
  // lower group terms and the carry-in, so no carry ripples between groups.
  always_comb begin
    logic acc;
    logic pp;
    cg    = '0;
    cg[0] = bus.C;
    for (int unsigned k = 0; k < NG; k++) begin
      acc = 1'b0;
      pp  = 1'b1;
      for (int unsigned jj = 0; jj < NG; jj++) begin
        if (jj <= k) begin
          acc = acc | (pp & gg[k-jj]);
          pp  = pp & gp[k-jj];
        end
      end
      cg[k+1] = acc | (pp & bus.C);
    end
  end

  // Per-bit carries expanded from the owning group's carry-in.
  always_comb begin
    logic acc;
    logic pp;
    int unsigned base;
    c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      base = (i / GROUP) * GROUP;
      acc  = 1'b0;
      pp   = 1'b1;
      for (int unsigned jj = 0; jj < GROUP; jj++) begin
        if (jj < i - base) begin
          acc = acc | (pp & g[i-1-jj]);
          pp  = pp & p[i-1-jj];
        end
      end
      c[i] = acc | (pp & cg[i/GROUP]);
    end
  end

  assign sum_c  = p ^ c;
  assign cout_c = cg[NG];

  // Result registers: capture on in_valid, otherwise hold and drop out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.S         <= '0;
      bus.C_out     <= 1'b0;
      bus.out_valid <= 1'b0;
    end else if (bus.in_valid) begin
      bus.S         <= sum_c;
      bus.C_out     <= cout_c;
      bus.out_valid <= 1'b1;
    end else begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder15.sv
// Self-checking bench for adder15: directed vector table, hold/reset
// sequences, and a random stream against an arithmetic reference.
module tb_adder15;

  localparam int unsigned W = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  adder15_if #(.WIDTH(W)) bus();

  adder15 #(.WIDTH(W), .GROUP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t vecs[7];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic v);
    bus.A        = a;
    bus.B        = b;
    bus.C        = c;
    bus.in_valid = v;
  endtask

  task automatic check_out(input string name, input logic [W-1:0] s,
                           input logic co, input logic ov);
    n_checks++;
    if (bus.S !== s || bus.C_out !== co || bus.out_valid !== ov) begin
      n_fail++;
      $display("FAIL %s: got S=%h C_out=%b out_valid=%b, expected S=%h C_out=%b out_valid=%b",
               name, bus.S, bus.C_out, bus.out_valid, s, co, ov);
    end
  endtask

  initial begin
    int unsigned  full;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rv;
    logic [W-1:0] exp_s;
    logic         exp_co;
    logic         exp_ov;

    vecs[0] = '{a: 15'h0034, b: 15'h0015, c: 1'b0, s: 15'h0049, co: 1'b0};
    vecs[1] = '{a: 15'h0034, b: 15'h7FFE, c: 1'b0, s: 15'h0032, co: 1'b1};
    vecs[2] = '{a: 15'h7FFE, b: 15'h7FFE, c: 1'b0, s: 15'h7FFC, co: 1'b1};
    vecs[3] = '{a: 15'h7FFF, b: 15'h7FFF, c: 1'b1, s: 15'h7FFF, co: 1'b1};
    vecs[4] = '{a: 15'h7FFF, b: 15'h0000, c: 1'b1, s: 15'h0000, co: 1'b1};
    vecs[5] = '{a: 15'h0000, b: 15'h0000, c: 1'b0, s: 15'h0000, co: 1'b0};
    vecs[6] = '{a: 15'h5555, b: 15'h2AAA, c: 1'b1, s: 15'h0000, co: 1'b1};

    // Reset held with live operands: outputs must stay cleared.
    drive(15'h1234, 15'h0FFF, 1'b0, 1'b1);
    #1;
    check_out("reset_initial", '0, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      check_out("reset_held", '0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b, vecs[i].c, 1'b1);
      @(posedge clk); #1;
      check_out($sformatf("vec%0d", i), vecs[i].s, vecs[i].co, 1'b1);
    end

    // Hold: drop in_valid and change operands; mid-cycle changes have no effect.
    @(negedge clk);
    drive(15'h0034, 15'h0015, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_out("hold_capture", 15'h0049, 1'b0, 1'b1);
    @(negedge clk);
    drive(15'h1111, 15'h2222, 1'b1, 1'b0);
    @(posedge clk); #1;
    check_out("hold", 15'h0049, 1'b0, 1'b0);
    #2;
    bus.A = 15'h7FFF;
    #1;
    check_out("hold_midcycle", 15'h0049, 1'b0, 1'b0);

    // Asynchronous reset between edges; the transaction in that window is lost.
    @(negedge clk);
    drive(15'h7FFF, 15'h7FFF, 1'b1, 1'b1);
    @(posedge clk); #1;
    check_out("pre_reset_capture", 15'h7FFF, 1'b1, 1'b1);
    @(negedge clk);
    drive(15'h0001, 15'h0002, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_out("lost_txn", '0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check_out("after_reset", '0, 1'b0, 1'b0);

    // Random back-to-back stream against plain arithmetic.
    exp_s  = '0;
    exp_co = 1'b0;
    exp_ov = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      rv = ($urandom_range(0, 9) != 0);
      if ((i % 97) == 0) begin
        ra = 15'h7FFF;
        rb = (i % 2 == 0) ? 15'h0000 : 15'h7FFF;
        rc = 1'b1;
      end
      drive(ra, rb, rc, rv);
      if (rv) begin
        full   = int'(ra) + int'(rb) + int'(rc);
        exp_s  = W'(full % 32768);
        exp_co = (full >= 32768);
      end
      exp_ov = rv;
      @(posedge clk); #1;
      check_out($sformatf("rand%0d", i), exp_s, exp_co, exp_ov);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder15.md
Name: adder15

Overview:
- Registered WIDTH-bit binary adder with carry-in and carry-out. Default width is 15 bits.
- Used as the datapath add unit. Computes S = A + B + C and captures the sum and carry-out in output registers.
- Single clock domain. Asynchronous active-low reset.

Parameters:
- WIDTH, 15, operand and sum width in bits (legal range 1..32).
- GROUP, 4, carry-lookahead group size in bits; the last group may be partial (15 = 4+4+4+3).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands are valid this cycle; capture the result
- A  input  WIDTH  operand A, unsigned
- B  input  WIDTH  operand B, unsigned
- C  input  1  carry-in
- S  output  WIDTH  registered sum, low WIDTH bits of A+B+C
- C_out  output  1  registered carry-out, bit WIDTH of A+B+C
- out_valid  output  1  S/C_out hold a result captured on the previous edge

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low; clock port clk, reset port rst_n.
- Reset: while rst_n=0, S=0, C_out=0 and out_valid=0 immediately, independent of clk. Registers stay cleared until the first rising edge after rst_n returns to 1.
- Arithmetic: the full sum {C_out,S} = A + B + C as a WIDTH+1-bit unsigned add.
  - No saturation.
  - Overflow wraps modulo 2^WIDTH, and the overflow bit appears on C_out.
- Carry structure: a combinational carry-lookahead network.
  - Per-bit generate g=A&B and propagate p=A^B.
  - Group generate/propagate over each GROUP slice.
  - Group carries from a second-level lookahead.
  - Sum bit = p ^ carry-in of that bit.
- Capture: on a rising clk edge with in_valid=1, S and C_out register the combinational result and out_valid becomes 1.
- Hold: on an edge with in_valid=0, S and C_out hold their previous values and out_valid becomes 0.
- Latency: exactly 1 cycle from the edge on which operands are sampled to the result being visible. Throughput is one add per cycle; back-to-back in_valid is allowed.
- Inputs are sampled only at the clock edge. Input changes between edges have no effect on the outputs.
- No X propagation from a held state: the outputs always reflect the last captured result or the reset value.
- Reset mid-operation: asserting rst_n=0 between edges clears the outputs at once. A transaction sampled in that window is lost and never reported.

Test Plan:
- Reset: hold rst_n=0 with A=0x1234, B=0x0FFF, in_valid=1 and toggle clk -> S=0x0000, C_out=0, out_valid=0 throughout.
- Basic add: A=0x0034, B=0x0015, C=0, in_valid=1, one edge -> S=0x0049, C_out=0, out_valid=1.
- Overflow into carry: A=0x0034, B=0x7FFE, C=0 -> S=0x0032, C_out=1.
- Max operands: A=0x7FFE, B=0x7FFE, C=0 -> S=0x7FFC, C_out=1. Then A=0x7FFF, B=0x7FFF, C=1 -> S=0x7FFF, C_out=1.
- Full ripple through all groups via carry-in: A=0x7FFF, B=0x0000, C=1 -> S=0x0000, C_out=1. Then A=0, B=0, C=0 -> S=0x0000, C_out=0.
- Hold and async reset:
  - Capture 0x0034+0x0015, then drop in_valid and change A/B -> S stays 0x0049, out_valid=0.
  - Pulse rst_n low mid-cycle -> S=0, C_out=0 immediately.
  - A random back-to-back stream of 1000 operand sets must match the reference sum A+B+C one cycle later.
